// File: rtl/mac_tree_pkg.sv
// mac_tree_pkg
//   Shared types and helpers for the mac_tree multiply-accumulate slice.
//   - stage_sb_t   : sideband that travels with every beat through the pipeline
//   - tree_depth   : number of registered adder levels for a given tap count
//   - level_count  : number of live elements at a given adder-tree level
//   - sat_or_trunc : output range reduction; clamps when MAC_TREE_SATURATE_EN
//                    is defined, otherwise keeps the low out_w bits
package mac_tree_pkg;

  // Sideband partial sums are carried at this fixed width; the accumulator
  // width of an instance must not exceed it.
  localparam int SB_PS_WIDTH = 64;

  typedef struct packed {
    logic                          valid;
    logic                          accumulate;
    logic                          last;
    logic signed [SB_PS_WIDTH-1:0] partial_sum;
  } stage_sb_t;

  function automatic int tree_depth(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Result is sign-extended back to SB_PS_WIDTH; callers keep the low out_w bits.
  function automatic logic signed [SB_PS_WIDTH-1:0] sat_or_trunc(
    input logic signed [SB_PS_WIDTH-1:0] value,
    input int                            out_w
  );
`ifdef MAC_TREE_SATURATE_EN
    logic signed [SB_PS_WIDTH-1:0] hi;
    logic signed [SB_PS_WIDTH-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
`else
    return (value <<< (SB_PS_WIDTH - out_w)) >>> (SB_PS_WIDTH - out_w);
`endif
  endfunction

endpackage

// File: rtl/mac_tree_adder_stage.sv
// mac_tree_adder_stage
//   One registered level of the adder tree. Adjacent elements are summed
//   pairwise; an unpaired odd element is registered unchanged. Sidebands are
//   registered alongside. All registers hold while en is low.
// Ports:
//   clk, rst_in      clock, synchronous active-high reset
//   en               advance the level (low while the result consumer stalls)
//   in_data/in_sb    IN_COUNT live elements (padded to MAX_COUNT) + sideband
//   out_data/out_sb  ceil(IN_COUNT/2) live elements (zero padded) + sideband
module mac_tree_adder_stage
  import mac_tree_pkg::*;
#(
  parameter int IN_COUNT  = 4,
  parameter int MAX_COUNT = 4,
  parameter int WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_in,
  input  logic                       en,
  input  logic [MAX_COUNT*WIDTH-1:0] in_data,
  input  stage_sb_t                  in_sb,
  output logic [MAX_COUNT*WIDTH-1:0] out_data,
  output stage_sb_t                  out_sb
);

  localparam int OUT_COUNT = (IN_COUNT + 1) / 2;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_COUNT; gi++) begin : g_node
      if (gi < OUT_COUNT) begin : g_live
        logic [WIDTH-1:0] sum_next;
        logic [WIDTH-1:0] node_reg;
        if (2 * gi + 1 < IN_COUNT) begin : g_pair
          assign sum_next = in_data[(2*gi)*WIDTH +: WIDTH]
                          + in_data[(2*gi+1)*WIDTH +: WIDTH];
        end else begin : g_pass
          assign sum_next = in_data[(2*gi)*WIDTH +: WIDTH];
        end
        always_ff @(posedge clk) begin
          if (rst_in) node_reg <= '0;
          else if (en) node_reg <= sum_next;
        end
        assign out_data[gi*WIDTH +: WIDTH] = node_reg;
      end else begin : g_pad
        assign out_data[gi*WIDTH +: WIDTH] = '0;
      end
    end

    if (IN_COUNT < MAX_COUNT) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^in_data[MAX_COUNT*WIDTH-1:IN_COUNT*WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_in) out_sb <= '0;
    else if (en) out_sb <= in_sb;
  end

endmodule

// File: rtl/mac_tree.sv
// mac_tree
//   N-tap multiply-accumulate: registered products (stage P), a pipelined
//   adder tree of tree_depth(NUM_TAPS) levels, then the accumulator / output
//   register (stage A). Bubbles are tracked per beat; the whole pipeline
//   freezes while a presented result is not taken.
//   Optional: define MAC_TREE_SATURATE_EN to clamp the scaled result to the
//   output range instead of truncating it.
// Ports:
//   clk, rst_in                  clock, synchronous active-high reset
//   in_valid / in_ready          operand beat handshake
//   a_in, b_in                   NUM_TAPS packed signed operands (tap 0 in LSBs)
//   accumulate_in                1: add onto accumulator, 0: add onto partial_sum_in
//   partial_sum_in               seed for a fresh accumulation
//   last_in                      beat closes an accumulation; result is presented
//   out / out_valid / out_ready  scaled result handshake
module mac_tree
  import mac_tree_pkg::*;
#(
  parameter int NUM_TAPS          = 4,
  parameter int A_WIDTH           = 16,
  parameter int B_WIDTH           = 16,
  parameter int ACCUMULATOR_WIDTH = 32,
  parameter int OUTPUT_WIDTH      = 16,
  parameter int OUTPUT_SCALE      = 0
) (
  input  logic                                clk,
  input  logic                                rst_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_TAPS*A_WIDTH-1:0]         a_in,
  input  logic [NUM_TAPS*B_WIDTH-1:0]         b_in,
  input  logic                                accumulate_in,
  input  logic signed [ACCUMULATOR_WIDTH-1:0] partial_sum_in,
  input  logic                                last_in,
  output logic signed [OUTPUT_WIDTH-1:0]      out,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int TD = tree_depth(NUM_TAPS);
  localparam int AW = ACCUMULATOR_WIDTH;
  localparam int PW = A_WIDTH + B_WIDTH;

  logic stall;
  logic en;
  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  // Level 0 is the product register; level TD feeds the accumulator.
  logic [NUM_TAPS*AW-1:0] lvl_data [TD+1];
  stage_sb_t              lvl_sb   [TD+1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_mul
      logic signed [A_WIDTH-1:0] a_s;
      logic signed [B_WIDTH-1:0] b_s;
      logic signed [PW-1:0]      prod;
      logic signed [AW-1:0]      prod_ext;
      logic [AW-1:0]             prod_reg;
      assign a_s      = a_in[gi*A_WIDTH +: A_WIDTH];
      assign b_s      = b_in[gi*B_WIDTH +: B_WIDTH];
      assign prod     = PW'(a_s) * PW'(b_s);
      assign prod_ext = AW'(prod);
      always_ff @(posedge clk) begin
        if (rst_in) prod_reg <= '0;
        else if (en) prod_reg <= prod_ext;
      end
      assign lvl_data[0][gi*AW +: AW] = prod_reg;
    end
  endgenerate

  stage_sb_t sb0_reg;
  always_ff @(posedge clk) begin
    if (rst_in) begin
      sb0_reg <= '0;
    end else if (en) begin
      sb0_reg.valid       <= in_valid;
      sb0_reg.accumulate  <= accumulate_in;
      sb0_reg.last        <= last_in;
      sb0_reg.partial_sum <= SB_PS_WIDTH'(partial_sum_in);
    end
  end
  assign lvl_sb[0] = sb0_reg;

  generate
    for (gi = 0; gi < TD; gi++) begin : g_level
      mac_tree_adder_stage #(
        .IN_COUNT (level_count(NUM_TAPS, gi)),
        .MAX_COUNT(NUM_TAPS),
        .WIDTH    (AW)
      ) u_stage (
        .clk     (clk),
        .rst_in  (rst_in),
        .en      (en),
        .in_data (lvl_data[gi]),
        .in_sb   (lvl_sb[gi]),
        .out_data(lvl_data[gi+1]),
        .out_sb  (lvl_sb[gi+1])
      );
    end
  endgenerate

  // Stage A
  logic signed [AW-1:0]          tree_sum;
  logic signed [AW-1:0]          seed;
  logic signed [AW-1:0]          acc_reg;
  logic signed [AW-1:0]          acc_next;
  logic signed [SB_PS_WIDTH-1:0] scaled;
  logic signed [SB_PS_WIDTH-1:0] limited;
  logic                          load_result;

  assign tree_sum    = lvl_data[TD][AW-1:0];
  assign seed        = lvl_sb[TD].accumulate ? acc_reg : lvl_sb[TD].partial_sum[AW-1:0];
  assign acc_next    = seed + tree_sum;
  assign scaled      = SB_PS_WIDTH'(acc_next) >>> OUTPUT_SCALE;
  assign limited     = sat_or_trunc(scaled, OUTPUT_WIDTH);
  assign load_result = lvl_sb[TD].valid && lvl_sb[TD].last;

  // Outside a stall out_valid is either 0 or being consumed, so its next
  // value is simply whether a new result loads (back-to-back keeps it high).
  always_ff @(posedge clk) begin
    if (rst_in) begin
      acc_reg   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= load_result;
      if (lvl_sb[TD].valid) acc_reg <= acc_next;
      if (load_result) out <= limited[OUTPUT_WIDTH-1:0];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{limited, lvl_sb[TD].partial_sum, lvl_data[TD]};

endmodule
